// File: rtl/fifo_loopback_mc.sv
// Multi-channel stream loopback: per-channel FIFOs merged onto one egress stream
// by a round-robin arbiter that holds its grant while the consumer stalls.
module fifo_loopback_mc #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned AFULL_THRESH = 3,
    localparam int unsigned CW          = $clog2(DEPTH + 1),
    localparam int unsigned IW          = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [IW-1:0]             out_chan,
    output logic [CHANNELS*CW-1:0]    count,
    output logic [CHANNELS-1:0]       afull
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [CHANNELS-1:0] nonempty;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [WIDTH-1:0]    head [CHANNELS];
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       lock_chan;
    logic                lock;
    logic [IW-1:0]       grant;
    logic                handshake;

    // First non-empty channel at or after start, searching cyclically.
    function automatic logic [IW-1:0] rr_pick(input logic [CHANNELS-1:0] ne,
                                              input logic [IW-1:0] start);
        logic [IW-1:0] sel;
        logic          found;
        int unsigned   idx;
        sel   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            idx = 32'(start) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!found && ne[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wptr;
        logic [PW-1:0]    rptr;
        logic [CW-1:0]    cnt;

        assign nonempty[i]         = (cnt != '0);
        assign in_ready[i]         = (cnt < CW'(DEPTH)) & ~flush;
        assign push[i]             = in_valid[i] & in_ready[i];
        assign pop[i]              = handshake & (grant == IW'(i));
        assign head[i]             = mem[rptr];
        assign count[i*CW +: CW]   = cnt;
        assign afull[i]            = (cnt >= CW'(AFULL_THRESH));

        always_ff @(posedge clk) begin
            if (push[i]) mem[wptr] <= in_data[i*WIDTH +: WIDTH];
        end

        // Pointers wrap naturally; count cannot overflow thanks to in_ready gating.
        always_ff @(posedge clk) begin
            if (!rst || flush) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push[i]) wptr <= wptr + PW'(1);
                if (pop[i])  rptr <= rptr + PW'(1);
                if (push[i] && !pop[i])      cnt <= cnt + CW'(1);
                else if (!push[i] && pop[i]) cnt <= cnt - CW'(1);
            end
        end
    end

    always_comb begin
        grant     = lock ? lock_chan : rr_pick(nonempty, rr_ptr);
        out_valid = (|nonempty) & ~flush;
        handshake = out_valid & out_ready;
        out_chan  = grant;
        out_data  = head[grant];
    end

    // Round-robin pointer and grant lock held across egress stalls.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_chan <= '0;
        end else if (handshake) begin
            lock   <= 1'b0;
            rr_ptr <= (grant == IW'(CHANNELS - 1)) ? '0 : grant + IW'(1);
        end else if (out_valid) begin
            lock      <= 1'b1;
            lock_chan <= grant;
        end
    end

endmodule

// File: tb/tb_fifo_loopback_mc.sv
// Scoreboard bench for fifo_loopback_mc: directed stimulus queues expected egress
// beats; a negedge monitor pops and compares on every handshake.
module tb_fifo_loopback_mc;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_chan;
    logic [5:0]  count;
    logic [1:0]  afull;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    fifo_loopback_mc #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .AFULL_THRESH(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_chan(out_chan), .count(count), .afull(afull)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every egress handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", {23'd0, out_chan, out_data}, 32'h1ff);
            else check("egress", {23'd0, out_chan, out_data}, {23'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        in_valid = v;
        in_data  = {d1, d0};
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd3);
        check({tag, "_count"},     32'(count),     32'd0);
        check({tag, "_afull"},     32'(afull),     32'd0);
        check({tag, "_out_chan"},  32'(out_chan),  32'd0);
    endtask

    logic [2:0] exp_cnt;

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(2'b00, 8'h00, 8'h00);

        // 1: reset and idle
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle("reset");
            tick();
        end

        // 2: single-channel latency and order
        out_ready = 1'b1;
        drive(2'b01, 8'h11, 8'h00); exp_q.push_back({1'b0, 8'h11});
        @(negedge clk);
        check("t2_no_bypass", 32'(out_valid), 32'd0);
        tick();
        drive(2'b01, 8'h22, 8'h00); exp_q.push_back({1'b0, 8'h22});
        @(negedge clk);
        check("t2_valid_rise", 32'(out_valid), 32'd1);
        tick();
        drive(2'b01, 8'h33, 8'h00); exp_q.push_back({1'b0, 8'h33});
        tick();
        drive(2'b00, 8'h00, 8'h00);
        tick(); tick();
        @(negedge clk);
        check("t2_count0", 32'(count[2:0]), 32'd0);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        tick();

        // 3: full / almost-full on ch1
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 8'h00, 8'(8'h51 + i));
            if (i < 4) exp_q.push_back({1'b1, 8'(8'h51 + i)});
            tick();
            exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
            @(negedge clk);
            check("t3_count1",    32'(count[5:3]),  32'(exp_cnt));
            check("t3_afull1",    32'(afull[1]),    32'(exp_cnt >= 3));
            check("t3_in_ready1", 32'(in_ready[1]), 32'(exp_cnt < 4));
        end
        drive(2'b00, 8'h00, 8'h00);
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t3_reopen", 32'(in_ready[1]), 32'd1);
        check("t3_count_after_pop", 32'(count[5:3]), 32'd3);
        tick(); tick(); tick(); tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_count1_zero", 32'(count[5:3]), 32'd0);

        // 4: round-robin fairness
        tick();
        drive(2'b11, 8'hA0, 8'hB0);
        tick();
        drive(2'b11, 8'hA1, 8'hB1);
        tick();
        drive(2'b00, 8'h00, 8'h00);
        exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b0, 8'hA1}); exp_q.push_back({1'b1, 8'hB1});
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: grant lock holds ch1 while ch0 fills
        tick();
        drive(2'b10, 8'h00, 8'hB0); exp_q.push_back({1'b1, 8'hB0});
        tick();
        drive(2'b01, 8'hC0, 8'h00); exp_q.push_back({1'b0, 8'hC0});
        @(negedge clk);
        check("t5_chan_pre", 32'(out_chan), 32'd1);
        tick();
        drive(2'b00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_lock_chan", 32'(out_chan), 32'd1);
            check("t5_lock_data", 32'(out_data), 32'hB0);
            check("t5_count0",    32'(count[2:0]), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // 6a: flush discards data and blocks the handshake for its cycle
        tick();
        drive(2'b11, 8'hD0, 8'hE0); tick();
        drive(2'b11, 8'hD1, 8'hE1); tick();
        @(negedge clk);
        check("t6_count_pre", 32'(count), 32'({3'd2, 3'd2}));
        flush = 1'b1;
        @(negedge clk);
        check("t6_flush_in_ready",  32'(in_ready),  32'd0);
        check("t6_flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        flush = 1'b0;
        drive(2'b00, 8'h00, 8'h00);
        @(negedge clk);
        check_idle("flush");

        // 6b: reset together with flush yields the reset state
        tick();
        drive(2'b11, 8'hD2, 8'hE2); tick(); tick();
        drive(2'b00, 8'h00, 8'h00);
        @(negedge clk);
        check("t6b_count_pre", 32'(count), 32'({3'd2, 3'd2}));
        rst = 1'b0; flush = 1'b1;
        tick();
        rst = 1'b1; flush = 1'b0;
        @(negedge clk);
        check_idle("rstflush");
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
